ahb_xfer_ctrl: RTL and testbench
================================

# ahb_xfer_ctrl

AHB-Lite slave transfer controller for the USB endpoint. It owns the address-phase/data-phase pipeline and sequences each accepted transfer onto either the byte-wide endpoint data buffer (addresses 0x00–0x3F) or the register file (0x40–0x7F). It inserts wait states for multi-byte and stalled buffer accesses, and generates the two-cycle AHB ERROR response.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, stall cycles allowed before a buffer access is aborted with ERROR (used only with the timeout feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- htrans  in  2  AHB transfer type; bit 1 set means NONSEQ/SEQ.
- haddr  in  7  byte address.
- hsize  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- hwrite  in  1  1 = write.
- hwdata  in  32  write data, valid throughout the data phase.
- hrdata  out  32  read data.
- hready  out  1  transfer-done / slave-ready.
- hresp  out  1  1 = ERROR.
- reg_rd_en, reg_wr_en  out  1  register-file strobes, one cycle.
- reg_addr  out  7, reg_size  out  2, reg_wdata  out  32  latched address-phase info and hwdata.
- reg_rdata  in  32  register read data, combinational from reg_addr.
- reg_err  in  1  register decoder rejects reg_addr/reg_size/write.
- buf_pop  out  1, buf_rdata  in  8, buf_empty  in  1  receive side of the data buffer.
- buf_push  out  1, buf_wdata  out  8, buf_full  in  1  transmit side of the data buffer.

## Operation
- Address phase is accepted when hsel & htrans[1] & hready. On acceptance the block latches haddr, hsize and hwrite.
- With hsel high but htrans[1] low, the response is OKAY with zero wait states and no side effects.
- States: IDLE, REG, BUF, ERR1, ERR2.
- Routing of an accepted transfer:
  - haddr[6]=1 → REG.
  - haddr[6]=0 with hsize≤2 and an aligned address → BUF.
  - Anything else (hsize=3, or a misaligned buffer access) → ERR1.
- REG is a single cycle.
  - If reg_err=0: assert reg_rd_en or reg_wr_en, drive hrdata = reg_rdata, hready=1, then go to IDLE, or accept the next transfer.
  - If reg_err=1: suppress the strobes and go to ERR1.
- BUF moves N = 1<<hsize bytes, one per cycle, using a byte counter cnt running 0..N-1.
  - Lane = haddr[1:0]+cnt, little-endian.
  - A write pushes hwdata[8*lane +: 8] when buf_full=0.
  - A read pops when buf_empty=0 and captures buf_rdata into hrdata[8*lane +: 8].
  - Stall cycles (full or empty) hold cnt and keep hready=0.
- hready=1 only in the cycle of the last byte transfer. In that cycle the final read byte is driven combinationally and the earlier bytes come from registers.
- ERR1 drives hready=0, hresp=1. ERR2 drives hready=1, hresp=1. ERR2 may accept a new address phase.
- Unused hrdata lanes read 0.

## Timing
- Reset values: state IDLE, hready=1, hresp=0, hrdata=0, all strobes 0, cnt=0.
- Latency, measured from the address-phase edge:
  - REG: data phase of 1 cycle.
  - BUF: N cycles plus stall cycles.
  - ERROR: exactly 2 cycles.
- buf_push and buf_pop are never asserted in the same cycle, and never while the buffer is full/empty respectively.
- A rst assertion mid-transfer aborts immediately. Bytes already pushed or popped are not rolled back.
- A byte transfer with stall cleared on the last byte completes in that same cycle.

## Configuration
- AHB_XFER_TIMEOUT_EN defined:
  - A stall counter runs in BUF and is cleared on every byte transfer.
  - On reaching TIMEOUT_CYCLES consecutive stall cycles, the block enters ERR1 and does no further push/pop.
- AHB_XFER_TIMEOUT_EN undefined: no counter; BUF stalls indefinitely.

## Structure
- Package ahb_xfer_pkg holds:
  - the state enum;
  - HTRANS/HSIZE encodings;
  - region constants BUF_BASE = 7'h00 and REG_BASE = 7'h40.
- Sub-module xfer_byte_seq holds:
  - cnt, lane computation and last-byte detection;
  - the optional timeout counter.

## Test plan
- Byte read of 0x48 with reg_rdata = 0x0000_0012 → reg_rd_en for one cycle, hrdata = 0x12, zero wait states.
- Word write of 0xA1B2C3D4 to 0x00 with the buffer not full → pushes D4, C3, B2, A1 on consecutive cycles; hready low for 3 cycles, then high.
- Half read at 0x02 with buf_empty high for 2 cycles then low, bytes 0x55, 0x66 → hrdata = 0x6655_0000 after 4 data-phase cycles.
- Half access to 0x01, or hsize=3 → hready 0/hresp 1 then hready 1/hresp 1, with no buffer or register strobe.
- With AHB_XFER_TIMEOUT_EN defined: byte write with buf_full held → ERROR begins after 16 stall cycles. rst asserted in a BUF stall → hready=1, hresp=0, state IDLE.

Source files
------------

// File: rtl/ahb_xfer_pkg.sv
// Shared encodings and routing helper for the AHB-Lite USB endpoint transfer controller.
package ahb_xfer_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REG  = 3'd1;
  localparam logic [2:0] S_BUF  = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;
  localparam logic [1:0] HSIZE_ILL  = 2'd3;

  localparam logic [6:0] BUF_BASE = 7'h00;
  localparam logic [6:0] REG_BASE = 7'h40;

  // Register window takes everything (the decoder flags bad sizes); the buffer needs natural alignment.
  function automatic logic [2:0] route_state(input logic [6:0] addr, input logic [1:0] size);
    logic aligned;
    aligned = (size == HSIZE_BYTE) ||
              (size == HSIZE_HALF && !addr[0]) ||
              (size == HSIZE_WORD && addr[1:0] == 2'b00);
    if ((addr & REG_BASE) == REG_BASE) return S_REG;
    if ((addr & REG_BASE) == BUF_BASE && aligned) return S_BUF;
    return S_ERR1;
  endfunction
endpackage

// File: rtl/xfer_byte_seq.sv
// Byte sequencer for buffer transfers: byte counter, lane and last-byte detect, optional
// stall timeout (enabled by AHB_XFER_TIMEOUT_EN).
module xfer_byte_seq #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       active,
  input  logic       xfer,
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic [1:0] lane,
  output logic       last,
  output logic       timeout
);
  logic [1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= 2'd0;
    else if (start)          cnt <= 2'd0;
    else if (active && xfer) cnt <= last ? 2'd0 : cnt + 2'd1;
  end

  assign lane = addr_lo + cnt;

  always_comb begin
    case (size)
      2'd0:    last = 1'b1;
      2'd1:    last = cnt[0];
      default: last = (cnt == 2'd3);
    endcase
  end

`ifdef AHB_XFER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [SW-1:0] scnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          scnt <= '0;
    else if (start || !active || xfer) scnt <= '0;
    else                              scnt <= scnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive stall cycle.
  assign timeout = active && !xfer && (scnt == SW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/ahb_xfer_ctrl.sv
// AHB-Lite slave transfer controller routing to the endpoint byte buffer or register file.
// Optional buffer stall timeout is enabled by defining AHB_XFER_TIMEOUT_EN.
module ahb_xfer_ctrl
  import ahb_xfer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [6:0]  haddr,
  input  logic [1:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        reg_rd_en,
  output logic        reg_wr_en,
  output logic [6:0]  reg_addr,
  output logic [1:0]  reg_size,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_err,
  output logic        buf_pop,
  input  logic [7:0]  buf_rdata,
  input  logic        buf_empty,
  output logic        buf_push,
  output logic [7:0]  buf_wdata,
  input  logic        buf_full
);
  logic [2:0]  state, nxt;
  logic [6:0]  a_addr;
  logic [1:0]  a_size;
  logic        a_write;
  logic [31:0] rdata_q;
  logic [1:0]  lane;
  logic        last, timeout, accept;

  assign accept    = hsel && htrans[1] && hready;
  assign reg_addr  = a_addr;
  assign reg_size  = a_size;
  assign reg_wdata = hwdata;
  assign buf_wdata = hwdata[{lane, 3'b000} +: 8];

  xfer_byte_seq #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .active  (state == S_BUF),
    .xfer    (buf_push || buf_pop),
    .addr_lo (a_addr[1:0]),
    .size    (a_size),
    .lane    (lane),
    .last    (last),
    .timeout (timeout)
  );

  always_comb begin
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    reg_rd_en = 1'b0;
    reg_wr_en = 1'b0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    case (state)
      S_REG: begin
        if (reg_err) hready = 1'b0;
        else begin
          reg_rd_en = !a_write;
          reg_wr_en = a_write;
          if (!a_write) hrdata = reg_rdata;
        end
      end
      S_BUF: begin
        buf_push = a_write && !buf_full;
        buf_pop  = !a_write && !buf_empty;
        hready   = (buf_push || buf_pop) && last;
        // Final read byte bypasses the register so it completes in its own cycle.
        if (!a_write)
          hrdata = rdata_q | (buf_pop ? (32'(buf_rdata) << {lane, 3'b000}) : 32'h0);
      end
      S_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      S_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    if (hready)                       nxt = accept ? route_state(haddr, hsize) : S_IDLE;
    else if (state == S_REG)          nxt = S_ERR1;
    else if (state == S_BUF)          nxt = timeout ? S_ERR1 : S_BUF;
    else if (state == S_ERR1)         nxt = S_ERR2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_addr  <= 7'h0;
      a_size  <= 2'd0;
      a_write <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_addr  <= haddr;
        a_size  <= hsize;
        a_write <= hwrite;
        rdata_q <= 32'h0;
      end else if (buf_pop) begin
        rdata_q[{lane, 3'b000} +: 8] <= buf_rdata;
      end
    end
  end
endmodule

// File: tb/tb_ahb_xfer_ctrl.sv
// Scoreboard bench for ahb_xfer_ctrl: directed AHB transfers, response and strobe queues.
module tb_ahb_xfer_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [6:0]  haddr = 7'h0;
  logic [1:0]  hsize = 2'd0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata;
  logic        hready, hresp;
  logic        reg_rd_en, reg_wr_en;
  logic [6:0]  reg_addr;
  logic [1:0]  reg_size;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_err = 1'b0;
  logic        buf_pop, buf_push;
  logic [7:0]  buf_rdata = 8'h0;
  logic [7:0]  buf_wdata;
  logic        buf_empty = 1'b1;
  logic        buf_full = 1'b0;

  ahb_xfer_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .haddr(haddr), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_size(reg_size),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_err(reg_err),
    .buf_pop(buf_pop), .buf_rdata(buf_rdata), .buf_empty(buf_empty),
    .buf_push(buf_push), .buf_wdata(buf_wdata), .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
    logic [7:0]  waits;
    logic        chk_rd;
  } exp_t;

  exp_t        rq[$];
  logic [43:0] evq[$];
  logic [7:0]  rxq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        stall_rd = 1'b0;
  logic        pop_pend = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void ev(input logic [3:0] k, input logic [6:0] a, input logic [31:0] d);
    evq.push_back({k, 1'b0, a, d});
  endfunction

  // Receive-buffer model: pops observed before the edge retire the head byte after it.
  always @(negedge clk) pop_pend = buf_pop;
  always @(posedge clk) begin
    logic [7:0] dummy;
    #2;
    if (pop_pend && rxq.size() > 0) dummy = rxq.pop_front();
    pop_pend  = 1'b0;
    buf_rdata = (rxq.size() > 0) ? rxq[0] : 8'h00;
    buf_empty = stall_rd || (rxq.size() == 0);
  end

  // Monitor: data-phase responses and strobe events against the queues.
  always @(negedge clk) begin : mon
    static logic        in_dp = 1'b0;
    static int          wcnt = 0;
    static exp_t        e;
    static logic [43:0] got;
    static int          n;
    if (rst) begin
      in_dp = 1'b0;
      wcnt  = 0;
    end else begin
      n = int'(buf_push) + int'(buf_pop) + int'(reg_rd_en) + int'(reg_wr_en);
      if (n != 0) begin
        chk("strobe_excl", 64'(n), 64'd1);
        if (buf_push) chk("push_while_full", 64'(buf_full), 64'd0);
        if (buf_pop)  chk("pop_while_empty", 64'(buf_empty), 64'd0);
        got = buf_push  ? {4'h1, 8'h0, 24'h0, buf_wdata} :
              buf_pop   ? {4'h2, 8'h0, 24'h0, buf_rdata} :
              reg_rd_en ? {4'h3, 1'b0, reg_addr, 30'h0, reg_size} :
                          {4'h4, 1'b0, reg_addr, reg_wdata};
        if (evq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_strobe: got %0h expected none", got);
        end else chk("strobe_event", 64'(got), 64'(evq.pop_front()));
      end
      if (in_dp) begin
        if (hready) begin
          if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: got hresp %0b expected none", hresp);
          end else begin
            e = rq.pop_front();
            chk("hresp", 64'(hresp), 64'(e.resp));
            chk("wait_states", 64'(wcnt), 64'(e.waits));
            if (e.chk_rd) chk("hrdata", 64'(hrdata), 64'(e.rdata));
          end
          wcnt = 0;
        end else begin
          wcnt++;
          if (wcnt > 400) begin
            n_cmp++; n_bad++;
            $display("FAIL data_phase_stuck: got %0d cycles expected completion", wcnt);
            in_dp = 1'b0;
            wcnt  = 0;
          end
        end
      end
      if (hready) in_dp = hsel && htrans[1];
    end
  end

  task automatic issue(input logic [6:0] a, input logic [1:0] sz, input logic wr,
                       input logic [31:0] wd, input logic exp_it, input logic [31:0] er,
                       input logic eresp, input int ew);
    logic ok;
    if (exp_it) rq.push_back('{rdata: er, resp: eresp, waits: ew[7:0], chk_rd: !wr && !eresp});
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (hready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL addr_phase_timeout: got hready 0 expected 1 at %0h", a);
    end
    @(posedge clk); #1;
    hwdata = wd; hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && evq.size() == 0) break;
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready", 64'(hready), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    chk("rst_strobes", 64'({reg_rd_en, reg_wr_en, buf_push, buf_pop}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Register byte read, zero wait
    reg_rdata = 32'h0000_0012;
    ev(4'h3, 7'h48, 32'd0);
    issue(7'h48, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0000_0012, 1'b0, 0);
    drain();

    // Register word write
    ev(4'h4, 7'h44, 32'hDEAD_BEEF);
    issue(7'h44, 2'd2, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 0);
    drain();

    // Buffer word write, little-endian byte order
    ev(4'h1, 7'h0, 32'hD4); ev(4'h1, 7'h0, 32'hC3); ev(4'h1, 7'h0, 32'hB2); ev(4'h1, 7'h0, 32'hA1);
    issue(7'h00, 2'd2, 1'b1, 32'hA1B2_C3D4, 1'b1, 32'h0, 1'b0, 3);
    drain();

    // Half read at 0x02 with two empty stall cycles
    rxq.push_back(8'h55); rxq.push_back(8'h66);
    stall_rd = 1'b1;
    ev(4'h2, 7'h0, 32'h55); ev(4'h2, 7'h0, 32'h66);
    issue(7'h02, 2'd1, 1'b0, 32'h0, 1'b1, 32'h6655_0000, 1'b0, 3);
    @(posedge clk); @(posedge clk); #1;
    stall_rd = 1'b0;
    drain();

    // Misaligned half and illegal size: two-cycle ERROR, no strobes
    issue(7'h01, 2'd1, 1'b1, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 1);
    drain();
    issue(7'h10, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
    drain();

    // Byte read at lane 1, other lanes zero
    rxq.push_back(8'h77);
    ev(4'h2, 7'h0, 32'h77);
    issue(7'h01, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0000_7700, 1'b0, 0);
    drain();

    // Byte write at lane 3
    ev(4'h1, 7'h0, 32'h11);
    issue(7'h03, 2'd0, 1'b1, 32'h1122_3344, 1'b1, 32'h0, 1'b0, 0);
    drain();

    // Register decoder reject: REG cycle then ERR1/ERR2
    reg_err = 1'b1;
    issue(7'h7C, 2'd2, 1'b1, 32'h0BAD_0BAD, 1'b1, 32'h0, 1'b1, 2);
    drain();
    reg_err = 1'b0;

    // Back-to-back: register read pipelined into buffer word read
    reg_rdata = 32'hCAFE_F00D;
    rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h03); rxq.push_back(8'h04);
    ev(4'h3, 7'h50, 32'd2);
    ev(4'h2, 7'h0, 32'h01); ev(4'h2, 7'h0, 32'h02); ev(4'h2, 7'h0, 32'h03); ev(4'h2, 7'h0, 32'h04);
    issue(7'h50, 2'd2, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 0);
    issue(7'h04, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0403_0201, 1'b0, 3);
    drain();

    // Half write with full stall on first cycle, cleared for the last byte
    buf_full = 1'b1;
    ev(4'h1, 7'h0, 32'hBB); ev(4'h1, 7'h0, 32'hAA);
    issue(7'h02, 2'd1, 1'b1, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0, 2);
    @(posedge clk); #1;
    buf_full = 1'b0;
    drain();

    // Selected but IDLE transfers: OKAY, zero wait, no strobes
    hsel = 1'b1; htrans = 2'b00; haddr = 7'h48;
    repeat (3) begin
      @(negedge clk);
      chk("idle_hready", 64'(hready), 64'd1);
      chk("idle_hresp", 64'(hresp), 64'd0);
    end
    @(posedge clk); #1;
    hsel = 1'b0;

`ifdef AHB_XFER_TIMEOUT_EN
    // Byte write stalled on full: 16 stall cycles, then ERROR
    buf_full = 1'b1;
    issue(7'h05, 2'd0, 1'b1, 32'h0000_9900, 1'b1, 32'h0, 1'b1, 17);
    drain();
    buf_full = 1'b0;
`endif

    // Reset during a stalled buffer write aborts it
    buf_full = 1'b1;
    issue(7'h08, 2'd2, 1'b1, 32'h5566_7788, 1'b0, 32'h0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_hready", 64'(hready), 64'd1);
    chk("midrst_hresp", 64'(hresp), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    buf_full = 1'b0;
    reg_rdata = 32'h0000_005A;
    ev(4'h3, 7'h40, 32'd0);
    issue(7'h40, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0000_005A, 1'b0, 0);
    drain();

    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    chk("event_queue_empty", 64'(evq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
